// File: rtl/mult_div_unit.sv
// Sequential signed 32x32 multiply / 32/32 divide unit producing HI/LO.
// Magnitudes are processed MSB-first over 32 cycles; signs are fixed up in FINISH.
module mult_div_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e      state_q, state_d;
  logic        op_q, op_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic        dz_q, dz_d;
  logic [31:0] mag_a_q, mag_a_d;
  logic [31:0] mag_b_q, mag_b_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        div_zero_q, div_zero_d;

  logic [31:0] mag_a_in, mag_b_in;
  logic        b_is_zero;
  logic [4:0]  bit_idx;
  logic [63:0] mul_step, div_step;
  logic [32:0] rem_shift, rem_diff;
  logic        q_bit;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  // |x| as a 32-bit unsigned value, so |0x80000000| stays 0x80000000.
  assign mag_a_in  = a[31] ? (~a + 32'd1) : a;
  assign mag_b_in  = b[31] ? (~b + 32'd1) : b;
  assign b_is_zero = (b == 32'd0);

  // Iteration k consumes operand bit 31-k.
  assign bit_idx   = ~cnt_q;
  assign mul_step  = {acc_q[62:0], 1'b0} + (mag_b_q[bit_idx] ? {32'd0, mag_a_q} : 64'd0);

  // acc holds {remainder, quotient} during a divide.
  assign rem_shift = {acc_q[63:32], mag_a_q[bit_idx]};
  assign rem_diff  = rem_shift - {1'b0, mag_b_q};
  assign q_bit     = ~rem_diff[32];
  assign div_step  = q_bit ? {rem_diff[31:0], acc_q[30:0], 1'b1}
                           : {rem_shift[31:0], acc_q[30:0], 1'b0};

  assign prod_fix  = (sign_a_q ^ sign_b_q) ? (~acc_q + 64'd1) : acc_q;
  assign quo_fix   = (sign_a_q ^ sign_b_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  assign rem_fix   = sign_a_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = (op && b_is_zero) ? StFinish : StRun;
      StRun:    if (cnt_q == 5'd31) state_d = StFinish;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    op_d       = op_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    dz_d       = dz_q;
    mag_a_d    = mag_a_q;
    mag_b_d    = mag_b_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d       = op;
          sign_a_d   = a[31];
          sign_b_d   = b[31];
          mag_a_d    = mag_a_in;
          mag_b_d    = mag_b_in;
          dz_d       = op && b_is_zero;
          cnt_d      = 5'd0;
          acc_d      = 64'd0;
          div_zero_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      StRun: begin
        acc_d = op_q ? div_step : mul_step;
        cnt_d = cnt_q + 5'd1;
      end
      StFinish: begin
        done_d = 1'b1;
        busy_d = 1'b0;
        if (dz_q) begin
          div_zero_d = 1'b1;
        end else if (op_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q       <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      dz_q       <= 1'b0;
      mag_a_q    <= 32'd0;
      mag_b_q    <= 32'd0;
      cnt_q      <= 5'd0;
      acc_q      <= 64'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      op_q       <= op_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      dz_q       <= dz_d;
      mag_a_q    <= mag_a_d;
      mag_b_q    <= mag_b_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus multi-cycle corner sequences.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  int n_checks = 0;
  int n_fail   = 0;

  mult_div_unit dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Present operands and pulse start across one rising edge (E0); returns #1 after E0.
  task automatic do_start(input logic o, input logic [31:0] x, input logic [31:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after E0 until done is seen (bounded); notes any early busy drop.
  task automatic wait_done(output int lat, output logic busy_ok);
    lat     = 0;
    busy_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      lat++;
      if (done === 1'b1) break;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  int   lat;
  logic busy_ok;
  int   done_seen;

  initial begin
    vecs[0] = '{1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[2] = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4] = '{1'b0, 32'd3,        32'd4,        32'h00000000, 32'h0000000C};
    vecs[5] = '{1'b1, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};
    vecs[6] = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[7] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[8] = '{1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};

    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = 32'd0;
    b     = 32'd0;
    #3;
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_div_zero", {31'd0, div_zero}, 32'd0);
    #9;
    reset = 1'b0;

    for (int v = 0; v < 9; v++) begin
      do_start(vecs[v].op, vecs[v].a, vecs[v].b);
      check($sformatf("v%0d_busy_e0", v), {31'd0, busy}, 32'd1);
      wait_done(lat, busy_ok);
      check($sformatf("v%0d_latency", v), lat, 32'd33);
      check($sformatf("v%0d_busy_span", v), {31'd0, busy_ok}, 32'd1);
      check($sformatf("v%0d_hi", v), hi, vecs[v].exp_hi);
      check($sformatf("v%0d_lo", v), lo, vecs[v].exp_lo);
      check($sformatf("v%0d_busy_done", v), {31'd0, busy}, 32'd0);
      check($sformatf("v%0d_div_zero", v), {31'd0, div_zero}, 32'd0);
      @(posedge clock);
      #1;
      check($sformatf("v%0d_done_pulse", v), {31'd0, done}, 32'd0);
    end

    // Divide by zero keeps prior hi/lo (0x11/0x22 from 0x2211 / 0x100).
    do_start(1'b1, 32'h2211, 32'h100);
    wait_done(lat, busy_ok);
    check("pre_dz_hi", hi, 32'h11);
    check("pre_dz_lo", lo, 32'h22);
    @(posedge clock);
    #1;
    do_start(1'b1, 32'd5, 32'd0);
    check("dz_no_flag_e0", {31'd0, div_zero}, 32'd0);
    wait_done(lat, busy_ok);
    check("dz_latency", lat, 32'd1);
    check("dz_flag", {31'd0, div_zero}, 32'd1);
    check("dz_busy", {31'd0, busy}, 32'd0);
    check("dz_hi", hi, 32'h11);
    check("dz_lo", lo, 32'h22);
    @(posedge clock);
    #1;
    check("dz_done_pulse", {31'd0, done}, 32'd0);
    check("dz_sticky", {31'd0, div_zero}, 32'd1);
    do_start(1'b0, 32'd2, 32'd5);
    check("dz_cleared_by_start", {31'd0, div_zero}, 32'd0);
    wait_done(lat, busy_ok);
    check("after_dz_lo", lo, 32'd10);
    @(posedge clock);
    #1;

    // A divide-by-zero start sampled at E10 of a mult must be ignored.
    do_start(1'b0, 32'd7, 32'hFFFFFFFD);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      if (lat == 9) begin
        op    = 1'b1;
        a     = 32'd5;
        b     = 32'd0;
        start = 1'b1;
      end
      @(posedge clock);
      #1;
      lat++;
      start = 1'b0;
      if (done === 1'b1) break;
    end
    check("ign_latency", lat, 32'd33);
    check("ign_hi", hi, 32'hFFFFFFFF);
    check("ign_lo", lo, 32'hFFFFFFEB);
    check("ign_div_zero", {31'd0, div_zero}, 32'd0);
    // Back-to-back start issued in the done cycle.
    do_start(1'b0, 32'd6, 32'd9);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(lat, busy_ok);
    check("b2b_latency", lat, 32'd33);
    check("b2b_lo", lo, 32'd54);
    @(posedge clock);
    #1;

    // Reset at E15 of a divide aborts it asynchronously.
    do_start(1'b1, 32'd100, 32'd7);
    repeat (14) @(posedge clock);
    @(posedge clock);
    reset = 1'b1;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    #12;
    reset     = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (done === 1'b1) done_seen++;
    end
    check("rst_no_done", done_seen, 32'd0);
    do_start(1'b0, 32'd3, 32'd4);
    wait_done(lat, busy_ok);
    check("post_rst_latency", lat, 32'd33);
    check("post_rst_hi", hi, 32'd0);
    check("post_rst_lo", lo, 32'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
